// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: the ME FSM state encoding, the width
// constants, and the cleared control word used to insert bubbles into the ME/WB register.
package pipeline_pkg;

    localparam int ME_DATA_W  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        ME_IDLE = 1'b0,
        ME_WAIT = 1'b1
    } me_state_t;

    // Control half of the ME/WB register; the data fields depend on the DATA_W parameter.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  fault;
    } me_wb_ctrl_t;

    localparam me_wb_ctrl_t ME_WB_BUBBLE = '{rd: 5'd0, reg_write: 1'b0, mem_to_reg: 1'b0, fault: 1'b0};

endpackage

// File: rtl/me_timeout_counter.sv
// Counts WAIT cycles of an outstanding bus transaction. It flags the last cycle
// before the transaction has to be aborted.
module me_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; clear takes priority over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_access_unit.sv
// ME stage of the 5-stage pipeline. ALU results pass straight through to ME/WB.
// Loads and stores run one req/ack bus transaction, which ends on an ack, a fault or a timeout.
module memory_access_unit
    import pipeline_pkg::*;
#(
    parameter int  DATA_W         = ME_DATA_W,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     EX_ME_ALU_result,
    input  logic [DATA_W-1:0]     EX_ME_rs2,
    input  logic [REG_ADDR_W-1:0] EX_ME_rd,
    input  logic                  EX_ME_RegWrite,
    input  logic                  EX_ME_MemRead,
    input  logic                  EX_ME_MemWrite,
    input  logic                  EX_ME_MemtoReg,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  ME_stall,
    output logic [DATA_W-1:0]     ME_WB_ALU_result,
    output logic [DATA_W-1:0]     ME_WB_read_data,
    output logic [REG_ADDR_W-1:0] ME_WB_rd,
    output logic                  ME_WB_RegWrite,
    output logic                  ME_WB_MemtoReg,
    output logic                  ME_WB_fault
);

    me_state_t   state_r, state_s;
    logic        req_r, req_s, we_r, we_s;
    logic [DATA_W-1:0] addr_r, addr_s, wdata_r, wdata_s;
    logic [DATA_W-1:0] cap_alu_r, cap_alu_s;
    me_wb_ctrl_t cap_ctrl_r, cap_ctrl_s;
    logic [DATA_W-1:0] wb_alu_r, wb_alu_s, wb_rdata_r, wb_rdata_s;
    me_wb_ctrl_t wb_ctrl_r, wb_ctrl_s;
    logic        mem_op_s, misaligned_s, stall_s;
    logic        cnt_clear_s, cnt_en_s, cnt_terminal_s;
    logic [CNT_W-1:0] cnt_s;

    me_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_en_s),
        .count   (cnt_s),
        .terminal(cnt_terminal_s)
    );

    assign mem_op_s     = EX_ME_MemRead | EX_ME_MemWrite;
    assign misaligned_s = mem_op_s & (EX_ME_ALU_result[1:0] != 2'b00);

    // Next-state, stall and next values for the bus and ME/WB registers.
    always_comb begin
        state_s     = state_r;
        req_s       = req_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        cap_alu_s   = cap_alu_r;
        cap_ctrl_s  = cap_ctrl_r;
        wb_alu_s    = {DATA_W{1'b0}};
        wb_rdata_s  = {DATA_W{1'b0}};
        wb_ctrl_s   = ME_WB_BUBBLE;
        stall_s     = 1'b0;
        cnt_clear_s = 1'b1;
        cnt_en_s    = 1'b0;
        case (state_r)
            ME_IDLE: begin
                if (!mem_op_s) begin
                    wb_alu_s             = EX_ME_ALU_result;
                    wb_ctrl_s.rd         = EX_ME_rd;
                    wb_ctrl_s.reg_write  = EX_ME_RegWrite;
                    wb_ctrl_s.mem_to_reg = EX_ME_MemtoReg;
                end else if (misaligned_s) begin
                    wb_alu_s        = EX_ME_ALU_result;
                    wb_ctrl_s.rd    = EX_ME_rd;
                    wb_ctrl_s.fault = 1'b1;
                end else begin
                    stall_s               = 1'b1;
                    req_s                 = 1'b1;
                    we_s                  = EX_ME_MemWrite;
                    addr_s                = EX_ME_ALU_result;
                    wdata_s               = EX_ME_rs2;
                    cap_alu_s             = EX_ME_ALU_result;
                    cap_ctrl_s.rd         = EX_ME_rd;
                    cap_ctrl_s.reg_write  = EX_ME_RegWrite;
                    cap_ctrl_s.mem_to_reg = EX_ME_MemtoReg;
                    cap_ctrl_s.fault      = 1'b0;
                    state_s               = ME_WAIT;
                end
            end
            ME_WAIT: begin
                stall_s = !mem_ack & !cnt_terminal_s;
                if (mem_ack) begin
                    req_s      = 1'b0;
                    state_s    = ME_IDLE;
                    wb_alu_s   = cap_alu_r;
                    wb_ctrl_s  = cap_ctrl_r;
                    wb_rdata_s = we_r ? {DATA_W{1'b0}} : mem_rdata;
                end else if (cnt_terminal_s) begin
                    req_s           = 1'b0;
                    state_s         = ME_IDLE;
                    wb_alu_s        = cap_alu_r;
                    wb_ctrl_s.rd    = cap_ctrl_r.rd;
                    wb_ctrl_s.fault = 1'b1;
                end else begin
                    cnt_clear_s = 1'b0;
                    cnt_en_s    = 1'b1;
                end
            end
            default: begin
                state_s = ME_IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State, bus and ME/WB registers; reset abandons any outstanding access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ME_IDLE;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {DATA_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            cap_alu_r  <= {DATA_W{1'b0}};
            cap_ctrl_r <= ME_WB_BUBBLE;
            wb_alu_r   <= {DATA_W{1'b0}};
            wb_rdata_r <= {DATA_W{1'b0}};
            wb_ctrl_r  <= ME_WB_BUBBLE;
        end else begin
            state_r    <= state_s;
            req_r      <= req_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            cap_alu_r  <= cap_alu_s;
            cap_ctrl_r <= cap_ctrl_s;
            wb_alu_r   <= wb_alu_s;
            wb_rdata_r <= wb_rdata_s;
            wb_ctrl_r  <= wb_ctrl_s;
        end
    end

    assign mem_req          = req_r;
    assign mem_we           = we_r;
    assign mem_addr         = addr_r;
    assign mem_wdata        = wdata_r;
    assign ME_stall         = stall_s;
    assign ME_WB_ALU_result = wb_alu_r;
    assign ME_WB_read_data  = wb_rdata_r;
    assign ME_WB_rd         = wb_ctrl_r.rd;
    assign ME_WB_RegWrite   = wb_ctrl_r.reg_write;
    assign ME_WB_MemtoReg   = wb_ctrl_r.mem_to_reg;
    assign ME_WB_fault      = wb_ctrl_r.fault;

    logic unused_s;
    assign unused_s = ^cnt_s;

endmodule
